// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared state encoding and default widths for the count sequence monitor
package count_mon_pkg;

   localparam int CW_DEF = 3;
   localparam int WW_DEF = 8;
   localparam int EW_DEF = 4;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [width-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {width{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - checks that an upstream up-counter steps by one each clock,
// counting legal wraps and sequence errors
module count_seq_monitor
   import count_mon_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int WW = WW_DEF,
   parameter int EW = EW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt_in,
   input  logic          clr,
   output logic          wrap_pulse,
   output logic [WW-1:0] wrap_cnt,
   output logic          err,
   output logic [EW-1:0] err_cnt,
   output logic          locked
);

   mon_state_t    state;
   mon_state_t    state_nxt;
   logic [CW-1:0] prev;
   logic [CW-1:0] expected;
   logic          match;
   logic          prev_max;
   logic          wrap_hit;
   logic          err_set;
   logic          err_inc;

   assign expected = prev + 1'b1;
   assign match    = (cnt_in == expected);
   assign prev_max = &prev;

   always_comb begin
      state_nxt = state;
      wrap_hit  = 1'b0;
      err_set   = 1'b0;
      err_inc   = 1'b0;
      case (state)
         INIT: begin
            state_nxt = TRACK;
         end
         TRACK: begin
            if (match) begin
               wrap_hit = prev_max;
            end else begin
               err_set   = 1'b1;
               err_inc   = 1'b1;
               state_nxt = FAULT;
            end
         end
         FAULT: begin
            // recovering through max->0 is not counted as a legal wrap
            if (match) begin
               state_nxt = TRACK;
            end else begin
               err_inc = 1'b1;
            end
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
      if (clr) begin
         state_nxt = INIT;
         wrap_hit  = 1'b0;
         err_set   = 1'b0;
         err_inc   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= INIT;
         prev       <= '0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev       <= cnt_in;
         wrap_pulse <= wrap_hit;
         // locked follows the next state so it rises together with TRACK
         locked     <= (state_nxt == TRACK);
         if (clr) begin
            wrap_cnt <= '0;
         end else if (wrap_hit) begin
            wrap_cnt <= wrap_cnt + 1'b1;
         end
         if (clr) begin
            err <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   sat_counter #(
      .width (EW)
   ) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_inc),
      .q   (err_cnt)
   );

endmodule

// File: doc/count_seq_monitor.md
COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CW, default 3, width of the monitored count.
REQ-003 Parameter WW, default 8, width of the wrap counter.
REQ-004 Parameter EW, default 4, width of the saturating error counter.
REQ-005 Port clk  input  1  rising-edge clock, shared with the upstream up-counter.
REQ-006 Port rst  input  1  asynchronous reset, active-low.
REQ-007 Port cnt_in  input  CW  count value produced by the upstream synchronous up-counter.
REQ-008 Port clr  input  1  synchronous clear of statistics and lock.
REQ-009 Port wrap_pulse  output  1  one-cycle pulse on a legal wrap from max to 0.
REQ-010 Port wrap_cnt  output  WW  number of legal wraps, modulo 2^WW.
REQ-011 Port err  output  1  sticky sequence-error flag.
REQ-012 Port err_cnt  output  EW  error count, saturating at 2^EW-1.
REQ-013 Port locked  output  1  high while the FSM is in TRACK.

Function
REQ-014 cnt_in SHALL be sampled at every rising edge; prev SHALL hold the sample from the previous edge; expected = (prev+1) mod 2^CW.
REQ-015 The FSM SHALL have three states: INIT, TRACK and FAULT; all outputs SHALL be registered and updated at the same edge that samples cnt_in.
REQ-016 INIT SHALL capture cnt_in into prev without checking it and SHALL go to TRACK at the next edge.
REQ-017 TRACK, cnt_in==expected: the FSM SHALL stay in TRACK.
REQ-018 TRACK, cnt_in==expected with prev==2^CW-1: wrap_pulse SHALL be 1 for exactly one cycle and wrap_cnt SHALL increment, rolling over from 2^WW-1 to 0.
REQ-019 TRACK, cnt_in!=expected (including a held value): err SHALL be set, err_cnt SHALL increment with saturation, and the FSM SHALL go to FAULT.
REQ-020 FAULT, cnt_in==expected: the FSM SHALL return to TRACK; err SHALL stay set; no wrap_pulse even if the transition was max to 0.
REQ-021 FAULT, cnt_in!=expected: err_cnt SHALL increment with saturation and the FSM SHALL stay in FAULT.
REQ-022 prev SHALL be updated from cnt_in at every edge in every state.
REQ-023 clr=1 SHALL, at that edge, clear wrap_cnt, err and err_cnt, deassert wrap_pulse, and force INIT; it SHALL take priority over any same-cycle wrap or error.
REQ-024 locked SHALL be 1 only in TRACK; the transition to TRACK and locked SHALL be visible in the same cycle.

Reset
REQ-025 While rst=0 the block SHALL hold: state=INIT, prev=0, wrap_pulse=0, wrap_cnt=0, err=0, err_cnt=0, locked=0.
REQ-026 Reset assertion mid-operation SHALL clear all registers immediately, without waiting for a clock edge.
REQ-027 After rst deasserts, the first edge SHALL be handled as INIT (no error check).

Structure
REQ-028 A shared package count_mon_pkg SHALL hold the state enum (INIT, TRACK, FAULT) and the default CW, WW and EW constants.
REQ-029 The saturating error counter SHALL be the sub-module sat_counter, with parameter width, inputs clk, rst, clr and inc, and output q.
REQ-030 No other sub-modules are required.

Verification
REQ-031 The bench SHALL drive reset low for 10 ns, then drive cnt_in 0,1,...,7,0,1 -> locked=1 from the 2nd edge, wrap_pulse once on sampling 0 after 7, wrap_cnt=1, err=0.
REQ-032 The bench SHALL drive cnt_in 3,4,4,5 -> err=1 and err_cnt=1 on the repeated 4, FAULT with locked=0, then TRACK on the 5.
REQ-033 The bench SHALL drive 20 consecutive mismatches -> err_cnt=15 (saturated) and err=1.
REQ-034 The bench SHALL assert clr in the same cycle as a 7 to 0 wrap -> wrap_pulse=0, wrap_cnt=0, err=0, then INIT followed by TRACK.
REQ-035 The bench SHALL run 256 wraps -> wrap_cnt rolls from 255 to 0 and wrap_pulse is still issued.
REQ-036 The bench SHALL pull rst low asynchronously between edges mid-count -> all outputs 0 within the same cycle, and no error on the first sample after release.
